// File: rtl/or2_stim_pkg.sv
// Shared types and constants for the OR2 cell stimulus/check stage.
//   state_e    : run sequencer states
//   VEC_ROM    : {B,A} vector sequence (rise/fall of each input plus 11 holds)
//   vec_at     : ROM lookup by vector index
//   expected_y : reference response of an ideal 2-input OR
package or2_stim_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned VEC_N = 8;
    localparam int unsigned VEC_W = 3;

    // Entries are {B,A}, index 0 first.
    localparam logic [1:0] VEC_ROM [VEC_N] = '{
        2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10
    };

    function automatic logic [1:0] vec_at(input logic [VEC_W-1:0] idx);
        return VEC_ROM[idx];
    endfunction

    function automatic logic expected_y(input logic [1:0] ba);
        return ba[1] | ba[0];
    endfunction

endpackage

// File: rtl/or2_glitch_mon.sv
// Counts extra toggles of the cell output inside each settle window.
// The first change after a new vector is the legitimate response; every
// further change in the same window is a glitch. Saturating count.
// Ports:
//   CLK, R      : clock, async active-low reset
//   clr         : clear the count (run start)
//   arm         : new vector being driven; forget the previous window
//   win         : settle window open
//   y           : cell output under observation
//   glitch_cnt  : registered saturating glitch count
module or2_glitch_mon #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             clr,
    input  logic             arm,
    input  logic             win,
    input  logic             y,
    output logic [ERR_W-1:0] glitch_cnt
);

    logic             y_q;
    logic             y_d;
    logic             seen_q;
    logic             seen_d;
    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;

    // Toggle detection against the previous-cycle sample of y.
    always_comb begin
        y_d    = y;
        seen_d = seen_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end
        if (arm) begin
            seen_d = 1'b0;
        end else if (win && (y != y_q)) begin
            if (seen_q) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + ERR_W'(1);
                end
            end else begin
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            y_q    <= 1'b0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            y_q    <= y_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign glitch_cnt = cnt_q;

endmodule

// File: rtl/or2_stim_check.sv
// Self-checking stimulus stage for a 2-input OR cell under test.
// Drives the cell A/B inputs from registers through the vector ROM, waits
// SETTLE_CYC cycles per vector, samples Y and compares it with A|B.
// Optional feature macro: OR2_STIM_GLITCH_EN adds glitch_cnt and folds it into pass.
// Ports:
//   CLK, R      : clock (rising edge), async active-low reset
//   start       : 1-cycle run request, honoured only in IDLE
//   dut_y       : cell output Y
//   stim_a/b    : registered cell inputs
//   busy        : run in progress
//   done        : 1-cycle end-of-run pulse
//   pass        : last run clean; held until next start
//   err_cnt     : saturating mismatch count of current/last run
//   fail_vec    : index of first failing vector
//   vec_idx     : index of vector currently applied
//   glitch_cnt  : (OR2_STIM_GLITCH_EN only) saturating extra-toggle count
module or2_stim_check
    import or2_stim_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LOOPS      = 1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic             dut_y,
    output logic             stim_a,
    output logic             stim_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic [2:0]       vec_idx
`ifdef OR2_STIM_GLITCH_EN
    ,
    output logic [ERR_W-1:0] glitch_cnt
`endif
);

    localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    state_e              state_q;
    state_e              state_d;
    logic [SET_W-1:0]    settle_cnt_q;
    logic [SET_W-1:0]    settle_cnt_d;
    logic [LOOP_W-1:0]   loop_cnt_q;
    logic [LOOP_W-1:0]   loop_cnt_d;
    logic [VEC_W-1:0]    vec_idx_q;
    logic [VEC_W-1:0]    vec_idx_d;
    logic                stim_a_q;
    logic                stim_a_d;
    logic                stim_b_q;
    logic                stim_b_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                pass_q;
    logic                pass_d;
    logic [ERR_W-1:0]    err_cnt_q;
    logic [ERR_W-1:0]    err_cnt_d;
    logic [2:0]          fail_vec_q;
    logic [2:0]          fail_vec_d;
    logic                glitch_ok_c;
    logic                last_vec_c;

`ifdef OR2_STIM_GLITCH_EN
    logic run_clr_c;
    logic drive_c;
    logic settle_c;

    assign run_clr_c = (state_q == IDLE) && start;
    assign drive_c   = (state_q == DRIVE);
    assign settle_c  = (state_q == SETTLE);

    or2_glitch_mon #(
        .ERR_W(ERR_W)
    ) u_glitch_mon (
        .CLK        (CLK),
        .R          (R),
        .clr        (run_clr_c),
        .arm        (drive_c),
        .win        (settle_c),
        .y          (dut_y),
        .glitch_cnt (glitch_cnt)
    );

    assign glitch_ok_c = (glitch_cnt == '0);
`else
    assign glitch_ok_c = 1'b1;
`endif

    assign last_vec_c = (vec_idx_q == VEC_W'(VEC_N - 1)) &&
                        (loop_cnt_q == LOOP_W'(LOOPS - 1));

    // State register.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) state_d = SAMPLE;
            SAMPLE:  state_d = last_vec_c ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        stim_a_d     = stim_a_q;
        stim_b_d     = stim_b_q;
        settle_cnt_d = settle_cnt_q;
        loop_cnt_d   = loop_cnt_q;
        vec_idx_d    = vec_idx_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        busy_d       = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_cnt_d  = '0;
                    fail_vec_d = '0;
                    pass_d     = 1'b0;
                    vec_idx_d  = '0;
                    loop_cnt_d = '0;
                end
            end
            DRIVE: begin
                {stim_b_d, stim_a_d} = vec_at(vec_idx_q);
                settle_cnt_d         = '0;
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
            SAMPLE: begin
                if (dut_y != expected_y(vec_at(vec_idx_q))) begin
                    // A zero count means this is the run's first mismatch.
                    if (err_cnt_q == '0) begin
                        fail_vec_d = vec_idx_q;
                    end
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                vec_idx_d = vec_idx_q + VEC_W'(1);
                if (vec_idx_q == VEC_W'(VEC_N - 1)) begin
                    loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                end
            end
            default: ;
        endcase

        // done and pass become visible together during the DONE cycle,
        // pass including the final sample's result.
        if (state_d == DONE) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0) && glitch_ok_c;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            stim_a_q     <= 1'b0;
            stim_b_q     <= 1'b0;
            settle_cnt_q <= '0;
            loop_cnt_q   <= '0;
            vec_idx_q    <= '0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            stim_a_q     <= stim_a_d;
            stim_b_q     <= stim_b_d;
            settle_cnt_q <= settle_cnt_d;
            loop_cnt_q   <= loop_cnt_d;
            vec_idx_q    <= vec_idx_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign stim_a   = stim_a_q;
    assign stim_b   = stim_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;
    assign vec_idx  = vec_idx_q;

endmodule

// File: tb/tb_or2_stim_check.sv
// Bench for or2_stim_check: a behavioural cell model (4-entry truth table
// indexed by {B,A}) answers the stimulus; expected run results are pushed
// into a queue at start and checked by a monitor when done pulses.
module tb_or2_stim_check;

    localparam int S1   = 4;
    localparam int L1   = 1;
    localparam int S2   = 2;
    localparam int L2   = 3;
    // Edges from the start-sampling edge to the edge after which done shows.
    localparam int LAT1 = L1 * 8 * (S1 + 2) + 1;
    localparam int LAT2 = L2 * 8 * (S2 + 2) + 1;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_STUCK = 4'b0000;

    typedef struct {
        int err;
        int fvec;
        int pass;
        int glitch;
        int t0;
    } exp_t;

    logic       CLK = 1'b0;
    logic       R;
    logic       start, start2;
    logic [3:0] lut, lut2;
    logic       glitch_mode, gy;
    logic       dut_y, dut_y2;
    logic       stim_a, stim_b, busy, done, pass;
    logic [7:0] err_cnt;
    logic [2:0] fail_vec, vec_idx;
    logic       stim_a2, stim_b2, busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [2:0] fail_vec2, vec_idx2;
`ifdef OR2_STIM_GLITCH_EN
    logic [7:0] glitch_cnt;
    logic [1:0] glitch_cnt2;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rom [8] = '{0, 1, 0, 2, 3, 1, 3, 2};
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign dut_y  = glitch_mode ? gy : lut[{stim_b, stim_a}];
    assign dut_y2 = lut2[{stim_b2, stim_a2}];

    or2_stim_check #(.SETTLE_CYC(S1), .LOOPS(L1), .ERR_W(8)) u_dut (
        .CLK(CLK), .R(R), .start(start), .dut_y(dut_y),
        .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec), .vec_idx(vec_idx)
`ifdef OR2_STIM_GLITCH_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    or2_stim_check #(.SETTLE_CYC(S2), .LOOPS(L2), .ERR_W(2)) u_dut2 (
        .CLK(CLK), .R(R), .start(start2), .dut_y(dut_y2),
        .stim_a(stim_a2), .stim_b(stim_b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .fail_vec(fail_vec2), .vec_idx(vec_idx2)
`ifdef OR2_STIM_GLITCH_EN
        , .glitch_cnt(glitch_cnt2)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: walk the vector list LOOPS times against the cell truth table.
    function automatic exp_t predict(input logic [3:0] tt, input int loops,
                                     input int errmax, input int glitch, input int t0);
        exp_t e;
        int   n = 0;
        e.fvec = 0;
        for (int l = 0; l < loops; l++) begin
            for (int v = 0; v < 8; v++) begin
                if (int'(tt[rom[v]]) != int'(rom[v] != 0)) begin
                    if (n == 0) e.fvec = v;
                    n++;
                end
            end
        end
        e.err    = (n > errmax) ? errmax : n;
        e.pass   = int'((n == 0) && (glitch == 0));
        e.glitch = glitch;
        e.t0     = t0;
        return e;
    endfunction

    // Monitor for the main instance: stimulus order and end-of-run results.
    int   sptr = 0;
    int   stim_p = 0;
    logic busy_p = 1'b0;
    always @(negedge CLK) begin
        int   sc;
        exp_t e;
        sc = int'({stim_b, stim_a});
        if (R === 1'b1) begin
            if (busy && !busy_p) sptr = (sc == rom[0]) ? 1 : 0;
            if (busy && sc != stim_p) begin
                chk("stim_seq", sc, rom[sptr % 8]);
                sptr++;
            end
            if (done) begin
                chk("done_expected", int'(exp_q1.size() > 0), 1);
                if (exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    chk("err_cnt", int'(err_cnt), e.err);
                    chk("fail_vec", int'(fail_vec), e.fvec);
                    chk("pass", int'(pass), e.pass);
                    chk("latency", cyc - e.t0, LAT1);
                    chk("busy_in_done", int'(busy), 0);
                    chk("stim_hold", sc, rom[7]);
                    chk("vec_count", sptr, 8 * L1);
`ifdef OR2_STIM_GLITCH_EN
                    chk("glitch_cnt", int'(glitch_cnt), e.glitch);
`endif
                end
            end
        end
        busy_p = busy;
        stim_p = sc;
    end

    // Monitor for the multi-loop, narrow-counter instance.
    always @(negedge CLK) begin
        exp_t e;
        if (R === 1'b1 && done2) begin
            chk("done2_expected", int'(exp_q2.size() > 0), 1);
            if (exp_q2.size() > 0) begin
                e = exp_q2.pop_front();
                chk("err_cnt2", int'(err_cnt2), e.err);
                chk("fail_vec2", int'(fail_vec2), e.fvec);
                chk("pass2", int'(pass2), e.pass);
                chk("latency2", cyc - e.t0, LAT2);
                chk("busy2_in_done", int'(busy2), 0);
            end
        end
    end

    task automatic wait_done1(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
    endtask

    task automatic wait_vec1(input int idx);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (int'(vec_idx) == idx) begin
                seen = 1;
                break;
            end
        end
        chk("vec_reached", int'(seen), 1);
    endtask

    // mode 0: plain run; 1: extra starts mid-run; 2: start coincident with done.
    task automatic run1(input logic [3:0] tt, input int mode);
        @(negedge CLK);
        lut = tt;
        exp_q1.push_back(predict(tt, L1, 255, 0, cyc));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        if (mode == 1) begin
            repeat (8) @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            chk("busy_after_restart_10", int'(busy), 1);
            repeat (9) @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            chk("busy_after_restart_20", int'(busy), 1);
        end
        wait_done1(200);
        if (mode == 2) begin
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            chk("busy_after_done_start", int'(busy), 0);
            repeat (60) @(negedge CLK);
            chk("idle_after_done_start", int'(busy), 0);
        end else begin
            @(negedge CLK);
        end
    endtask

    task automatic run2(input logic [3:0] tt);
        bit seen = 0;
        @(negedge CLK);
        lut2 = tt;
        exp_q2.push_back(predict(tt, L2, 3, 0, cyc));
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (done2) begin
                seen = 1;
                break;
            end
        end
        chk("done2_seen", int'(seen), 1);
        @(negedge CLK);
    endtask

    initial begin
        R = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        lut = TT_OR;
        lut2 = TT_OR;
        glitch_mode = 1'b0;
        gy = 1'b0;
        #2 R = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_stim_a", int'(stim_a), 0);
        chk("rst_stim_b", int'(stim_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_fail_vec", int'(fail_vec), 0);
        chk("rst_vec_idx", int'(vec_idx), 0);
        chk("rst_busy2", int'(busy2), 0);
        R = 1'b1;
        repeat (2) @(negedge CLK);

        run1(TT_OR, 0);
        run1(TT_STUCK, 0);
        run1(TT_AND, 0);
        for (int i = 0; i < 6; i++) run1(4'($urandom_range(0, 15)), 0);
        run1(TT_OR, 1);
        run1(TT_AND, 2);

        // Reset during the settle window of vector 4 aborts the run silently.
        @(negedge CLK);
        lut = TT_STUCK;
        exp_q1.push_back(predict(TT_STUCK, L1, 255, 0, cyc));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_vec1(4);
        @(negedge CLK);
        #2 R = 1'b0;
        #1;
        chk("abort_stim_a", int'(stim_a), 0);
        chk("abort_stim_b", int'(stim_b), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_err_cnt", int'(err_cnt), 0);
        chk("abort_fail_vec", int'(fail_vec), 0);
        chk("abort_vec_idx", int'(vec_idx), 0);
        exp_q1.delete();
        repeat (2) @(negedge CLK);
        R = 1'b1;
        repeat (60) @(negedge CLK);
        run1(TT_OR, 0);

        run2(TT_AND);
        run2(TT_STUCK);
        run2(TT_OR);

`ifdef OR2_STIM_GLITCH_EN
        // Y goes 0->1->0->1 in the settle window of vector 1: two extra toggles.
        @(negedge CLK);
        lut = TT_OR;
        exp_q1.push_back(predict(TT_OR, L1, 255, 2, cyc));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_vec1(1);
        gy = 1'b0;
        glitch_mode = 1'b1;
        @(negedge CLK);
        gy = 1'b1;
        @(negedge CLK);
        gy = 1'b0;
        @(negedge CLK);
        gy = 1'b1;
        repeat (4) @(negedge CLK);
        glitch_mode = 1'b0;
        wait_done1(200);
        @(negedge CLK);
`endif

        chk("queue_drained", exp_q1.size() + exp_q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
